// File: rtl/particle_serial_link.sv
// Per-channel serializer/deserializer for neighbour-bin particle exchange.
// Each channel is an independent TX shift FSM plus an RX reassembly buffer.
module particle_serial_link #(
  parameter int NUM_CH     = 6,
  parameter int DATA_WIDTH = 160,
  parameter int SER_WIDTH  = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_CH*DATA_WIDTH-1:0]   tx_data,
  input  logic [NUM_CH-1:0]              tx_valid,
  output logic [NUM_CH-1:0]              tx_ready,
  output logic [NUM_CH*SER_WIDTH-1:0]    ser_out,
  output logic [NUM_CH-1:0]              ser_out_valid,
  input  logic [NUM_CH*SER_WIDTH-1:0]    ser_in,
  input  logic [NUM_CH-1:0]              ser_in_valid,
  output logic [NUM_CH*DATA_WIDTH-1:0]   rx_data,
  output logic [NUM_CH-1:0]              rx_valid,
  input  logic [NUM_CH-1:0]              rx_ready,
  output logic [NUM_CH-1:0]              rx_overflow
);

  localparam int BEATS = DATA_WIDTH / SER_WIDTH;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);
  localparam logic [DATA_WIDTH-1:0] SLICE_MASK = DATA_WIDTH'({SER_WIDTH{1'b1}});

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } tx_state_e;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    // ---------------- TX ----------------
    tx_state_e             state, state_next;
    logic [CW-1:0]         tx_cnt;
    logic [DATA_WIDTH-1:0] tx_word;
    logic [DATA_WIDTH-1:0] tx_in;
    logic [DATA_WIDTH-1:0] tx_shifted;
    logic [SER_WIDTH-1:0]  ser_lane;
    logic                  ser_vld;
    logic                  tx_last;
    logic                  accept;

    assign tx_in       = tx_data[c*DATA_WIDTH +: DATA_WIDTH];
    assign tx_last     = (tx_cnt == LAST);
    assign tx_ready[c] = (state == IDLE) || ((state == SHIFT) && tx_last);
    assign accept      = tx_valid[c] && tx_ready[c];
    // The next slice is taken by shifting the held word, so the counter never
    // has to index beyond its own width.
    assign tx_shifted  = tx_word >> (SER_WIDTH * (int'(tx_cnt) + 1));

    // NOTE: every signal written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
      state_next = state;
      case (state)
        IDLE:    if (accept) state_next = SHIFT;
        SHIFT:   if (tx_last && !accept) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, and the word
    // registers are reset along with the control so outputs start at zero.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state    <= IDLE;
        tx_cnt   <= '0;
        tx_word  <= '0;
        ser_lane <= '0;
        ser_vld  <= 1'b0;
      end else begin
        state <= state_next;
        if (accept) begin
          tx_word  <= tx_in;
          ser_lane <= tx_in[SER_WIDTH-1:0];
          ser_vld  <= 1'b1;
          tx_cnt   <= '0;
        end else if (state == SHIFT) begin
          if (!tx_last) begin
            tx_cnt   <= tx_cnt + CW'(1);
            ser_lane <= tx_shifted[SER_WIDTH-1:0];
          end else begin
            ser_vld <= 1'b0;   // lane keeps its last value while idle
          end
        end
      end
    end

    assign ser_out[c*SER_WIDTH +: SER_WIDTH] = ser_lane;
    assign ser_out_valid[c]                  = ser_vld;

    // ---------------- RX ----------------
    logic [CW-1:0]         rx_cnt;
    logic [DATA_WIDTH-1:0] rx_asm;
    logic [DATA_WIDTH-1:0] rx_merged;
    logic [DATA_WIDTH-1:0] rx_word;
    logic [SER_WIDTH-1:0]  lane_in;
    logic                  rx_vld;
    logic                  rx_ovf;
    logic                  rx_done;

    assign lane_in   = ser_in[c*SER_WIDTH +: SER_WIDTH];
    assign rx_done   = ser_in_valid[c] && (rx_cnt == LAST);
    // Assembly buffer with the incoming beat already merged in, so the
    // completing beat can be delivered in the same edge.
    assign rx_merged = (rx_asm & ~(SLICE_MASK << (SER_WIDTH * int'(rx_cnt))))
                     | (DATA_WIDTH'(lane_in) << (SER_WIDTH * int'(rx_cnt)));

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rx_cnt  <= '0;
        rx_asm  <= '0;
        rx_word <= '0;
        rx_vld  <= 1'b0;
        rx_ovf  <= 1'b0;
      end else begin
        if (ser_in_valid[c]) begin
          rx_asm <= rx_merged;
          rx_cnt <= rx_done ? '0 : rx_cnt + CW'(1);
        end
        if (rx_done) begin
          if (!rx_vld || rx_ready[c]) begin
            rx_word <= rx_merged;
            rx_vld  <= 1'b1;
          end else begin
            rx_ovf <= 1'b1;    // held word wins; new word is dropped
          end
        end else if (rx_vld && rx_ready[c]) begin
          rx_vld <= 1'b0;
        end
      end
    end

    assign rx_data[c*DATA_WIDTH +: DATA_WIDTH] = rx_word;
    assign rx_valid[c]                         = rx_vld;
    assign rx_overflow[c]                      = rx_ovf;
  end

endmodule

// File: tb/tb_particle_serial_link.sv
// Bench for particle_serial_link: a 1-bit-lane instance for timing, RX flow
// control and reset, and an 8-bit-lane looped-back instance with a scoreboard.
module tb_particle_serial_link;

  localparam int NC = 6;
  localparam int DW = 160;

  typedef struct {
    int            ch;
    logic [DW-1:0] word;
  } xfer_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- instance with SER_WIDTH=1 ----------------
  logic [NC*DW-1:0] tx_data1 = '0;
  logic [NC-1:0]    tx_valid1 = '0, tx_ready1;
  logic [NC-1:0]    ser_out1, sov1, ser_in1, siv1;
  logic [NC-1:0]    inj1 = '0, inj_v1 = '0;
  logic             lb1 = 1'b0;
  logic [NC*DW-1:0] rx_data1;
  logic [NC-1:0]    rx_valid1, rx_ovf1;
  logic [NC-1:0]    rx_ready1 = '0;

  assign ser_in1 = lb1 ? ser_out1 : inj1;
  assign siv1    = lb1 ? sov1     : inj_v1;

  particle_serial_link #(.NUM_CH(NC), .DATA_WIDTH(DW), .SER_WIDTH(1)) u_s1 (
    .clk(clk), .rst(rst),
    .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_ready(tx_ready1),
    .ser_out(ser_out1), .ser_out_valid(sov1),
    .ser_in(ser_in1), .ser_in_valid(siv1),
    .rx_data(rx_data1), .rx_valid(rx_valid1), .rx_ready(rx_ready1),
    .rx_overflow(rx_ovf1)
  );

  // ---------------- instance with SER_WIDTH=8, looped back ----------------
  logic [NC*DW-1:0] tx_data8 = '0;
  logic [NC-1:0]    tx_valid8 = '0, tx_ready8;
  logic [NC*8-1:0]  ser_out8;
  logic [NC-1:0]    sov8;
  logic [NC*DW-1:0] rx_data8;
  logic [NC-1:0]    rx_valid8, rx_ovf8;
  logic [NC-1:0]    rx_ready8 = '1;

  particle_serial_link #(.NUM_CH(NC), .DATA_WIDTH(DW), .SER_WIDTH(8)) u_s8 (
    .clk(clk), .rst(rst),
    .tx_data(tx_data8), .tx_valid(tx_valid8), .tx_ready(tx_ready8),
    .ser_out(ser_out8), .ser_out_valid(sov8),
    .ser_in(ser_out8), .ser_in_valid(sov8),
    .rx_data(rx_data8), .rx_valid(rx_valid8), .rx_ready(rx_ready8),
    .rx_overflow(rx_ovf8)
  );

  xfer_t sb[$];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every word consumed on the looped 8-bit instance must match
  // the oldest word offered, on the same channel.
  always @(negedge clk) begin
    if (!rst) begin
      for (int c = 0; c < NC; c++) begin
        if (rx_valid8[c] && rx_ready8[c]) begin
          if (sb.size() == 0) begin
            check("sb_unexpected_word", 1, 0);
          end else begin
            xfer_t e;
            e = sb.pop_front();
            check("sb_channel", c, e.ch);
            check("sb_word", rx_data8[c*DW +: DW], e.word);
          end
        end
      end
    end
  end

  task automatic send8(input int ch, input logic [DW-1:0] w);
    int    guard;
    xfer_t t;
    guard = 0;
    tx_data8[ch*DW +: DW] = w;
    tx_valid8[ch] = 1'b1;
    while (!tx_ready8[ch] && guard < 100) begin
      tick();
      guard++;
    end
    if (guard >= 100) check("send8_ready_timeout", 0, 1);
    t.ch = ch;
    t.word = w;
    sb.push_back(t);
    tick();
    tx_valid8[ch] = 1'b0;
  endtask

  // Drives n beats of w on channel 0 of the 1-bit instance starting at slice 'from'.
  task automatic inject1(input logic [DW-1:0] w, input int from, input int n);
    for (int k = from; k < from + n; k++) begin
      inj1[0]   = w[k];
      inj_v1[0] = 1'b1;
      tick();
    end
    inj_v1[0] = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    xfer_t         vecs[6];
    logic [DW-1:0] w_a5, w_a, w_b, w_c, w_d, w_e, w_f, w_g, w1, w2;
    logic [DW-1:0] got;
    logic [63:0]   rdy_mask, sov_mask, exp_sov;
    logic [39:0]   exp_rdy;
    logic          all_valid, take;
    int            acc;

    w_a5 = {20{8'hA5}};
    w_a  = {$urandom, $urandom, $urandom, $urandom, $urandom};
    w_b  = {$urandom, $urandom, $urandom, $urandom, $urandom};
    w_c  = ~w_b;
    w_d  = {$urandom, $urandom, $urandom, $urandom, $urandom};
    w_e  = {$urandom, $urandom, $urandom, $urandom, $urandom};
    w_f  = {DW{1'b1}};
    w_g  = {$urandom, $urandom, $urandom, $urandom, 32'h1234_5679};
    w1   = {$urandom, $urandom, $urandom, $urandom, $urandom};
    w2   = {$urandom, $urandom, $urandom, $urandom, $urandom};
    vecs[0] = '{ch: 3, word: {$urandom, $urandom, $urandom, $urandom, $urandom}};
    vecs[1] = '{ch: 0, word: {DW{1'b1}}};
    vecs[2] = '{ch: 5, word: {80{2'b10}}};
    vecs[3] = '{ch: 1, word: 160'h1};
    vecs[4] = '{ch: 4, word: {1'b1, 159'h0}};
    vecs[5] = '{ch: 2, word: {$urandom, $urandom, $urandom, $urandom, $urandom}};

    // ---- reset state ----
    repeat (3) tick();
    check("rst_sov_during", sov1, 0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_tx_ready_s1", tx_ready1, {NC{1'b1}});
    check("rst_tx_ready_s8", tx_ready8, {NC{1'b1}});
    check("rst_ser_out", {ser_out8, ser_out1}, 0);
    check("rst_rx_valid", {rx_valid8, rx_valid1}, 0);
    check("rst_rx_overflow", {rx_ovf8, rx_ovf1}, 0);
    check("rst_rx_data_ch0", rx_data1[DW-1:0], 0);
    tick();

    // ---- 1-bit loopback: latency and beat order ----
    lb1 = 1'b1;
    tx_data1[DW-1:0] = w_a5;
    tx_valid1[0] = 1'b1;
    tick();                              // edge N
    tx_valid1[0] = 1'b0;
    all_valid = 1'b1;
    got = '0;
    for (int k = 0; k < DW; k++) begin
      got[k] = ser_out1[0];
      all_valid = all_valid & sov1[0];
      if (k < DW - 1) tick();
    end
    check("lb1_beats", got, w_a5);
    check("lb1_valid_all_beats", all_valid, 1);
    check("lb1_rx_not_early", rx_valid1[0], 0);
    tick();                              // edge N+160
    check("lb1_rx_valid", rx_valid1, 6'b000001);
    check("lb1_rx_data", rx_data1[DW-1:0], w_a5);
    check("lb1_sov_drop", sov1[0], 0);
    check("lb1_ser_out_hold", ser_out1[0], w_a5[DW-1]);
    rx_ready1[0] = 1'b1;
    tick();
    rx_ready1[0] = 1'b0;
    check("lb1_consume", rx_valid1[0], 0);
    lb1 = 1'b0;

    // ---- 8-bit: two words back-to-back with tx_valid held ----
    rdy_mask = '0;
    sov_mask = '0;
    acc = 0;
    tx_data8[DW-1:0] = w1;
    tx_valid8[0] = 1'b1;
    for (int i = 0; i < 48; i++) begin
      @(negedge clk);
      rdy_mask[i] = tx_ready8[0];
      sov_mask[i] = sov8[0];
      take = tx_ready8[0] && tx_valid8[0];
      @(posedge clk);
      #1;
      if (take) begin
        xfer_t t;
        t.ch = 0;
        t.word = tx_data8[DW-1:0];
        sb.push_back(t);
        acc++;
        if (acc == 1) tx_data8[DW-1:0] = w2;
        else tx_valid8[0] = 1'b0;
      end
    end
    exp_rdy = 40'd1 | (40'd1 << 20);
    exp_sov = ((64'd1 << 41) - 64'd1) & ~64'd1;
    check("b2b_tx_ready_pattern", rdy_mask[39:0], exp_rdy);
    check("b2b_sov_40_contiguous", sov_mask, exp_sov);
    check("b2b_accepts", acc, 2);

    // ---- 8-bit: table of single-channel words ----
    for (int v = 0; v < 6; v++) begin
      send8(vecs[v].ch, vecs[v].word);
      repeat (24) tick();
    end

    // ---- 8-bit: all channels at once ----
    for (int c = 0; c < NC; c++) begin
      xfer_t t;
      t.ch = c;
      t.word = {$urandom, $urandom, $urandom, $urandom, 32'(c)};
      tx_data8[c*DW +: DW] = t.word;
      sb.push_back(t);
    end
    tx_valid8 = '1;
    tick();
    tx_valid8 = '0;
    repeat (24) tick();
    check("sb_drained", sb.size(), 0);

    // ---- RX pause mid-frame ----
    inject1(w_a, 0, 80);
    repeat (10) tick();
    check("pause_no_valid", rx_valid1[0], 0);
    inject1(w_a, 80, 80);
    check("pause_valid", rx_valid1[0], 1);
    check("pause_word", rx_data1[DW-1:0], w_a);
    rx_ready1[0] = 1'b1;
    tick();
    rx_ready1[0] = 1'b0;
    check("pause_consume", rx_valid1[0], 0);

    // ---- completion coincident with consume ----
    inject1(w_d, 0, DW);
    inject1(w_e, 0, DW - 1);
    check("coinc_old_held", rx_data1[DW-1:0], w_d);
    inj1[0] = w_e[DW-1];
    inj_v1[0] = 1'b1;
    rx_ready1[0] = 1'b1;
    tick();
    inj_v1[0] = 1'b0;
    rx_ready1[0] = 1'b0;
    check("coinc_new_word", rx_data1[DW-1:0], w_e);
    check("coinc_valid", rx_valid1[0], 1);
    check("coinc_no_overflow", rx_ovf1[0], 0);
    rx_ready1[0] = 1'b1;
    tick();
    rx_ready1[0] = 1'b0;

    // ---- overflow ----
    inject1(w_b, 0, DW);
    check("ovf_first_no_flag", rx_ovf1[0], 0);
    inject1(w_c, 0, DW);
    check("ovf_old_kept", rx_data1[DW-1:0], w_b);
    check("ovf_flag", rx_ovf1[0], 1);
    rx_ready1[0] = 1'b1;
    tick();
    rx_ready1[0] = 1'b0;
    check("ovf_consume", rx_valid1[0], 0);
    check("ovf_sticky", rx_ovf1[0], 1);
    check("ovf_other_channels", rx_ovf1[NC-1:1], 0);

    // ---- reset mid-frame ----
    lb1 = 1'b1;
    tx_data1[DW-1:0] = w_f;
    tx_valid1[0] = 1'b1;
    tick();
    tx_valid1[0] = 1'b0;
    repeat (50) tick();
    rst = 1'b1;
    #1;
    check("midrst_sov", sov1, 0);
    check("midrst_ser_out", ser_out1, 0);
    check("midrst_overflow", rx_ovf1, 0);
    check("midrst_rx_valid", rx_valid1, 0);
    check("midrst_tx_ready", tx_ready1, {NC{1'b1}});
    tick();
    rst = 1'b0;
    check("postrst_tx_ready", tx_ready1, {NC{1'b1}});
    tx_data1[DW-1:0] = w_g;
    tx_valid1[0] = 1'b1;
    tick();
    tx_valid1[0] = 1'b0;
    repeat (DW) tick();
    check("postrst_rx_valid", rx_valid1[0], 1);
    check("postrst_rx_word", rx_data1[DW-1:0], w_g);
    check("postrst_no_overflow", rx_ovf1[0], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
